// File: rtl/vector_add_rr_scheduler.sv
// Shares one PE-lane element-wise adder among NREQ stream requesters.
// Vector-granular round-robin grant, joined operand pair, registered tagged AXI-Stream output.
module vector_add_rr_scheduler #(
    parameter  int NREQ   = 2,
    parameter  int PE     = 8,
    parameter  int ELEM_W = 8,
    parameter  int LEN_W  = 16,
    localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NREQ*PE*ELEM_W-1:0]    req_in0_TDATA,
    input  logic [NREQ-1:0]              req_in0_TVALID,
    output logic [NREQ-1:0]              req_in0_TREADY,
    input  logic [NREQ*PE*ELEM_W-1:0]    req_in1_TDATA,
    input  logic [NREQ-1:0]              req_in1_TVALID,
    output logic [NREQ-1:0]              req_in1_TREADY,
    input  logic [NREQ*LEN_W-1:0]        req_len,
    output logic [PE*ELEM_W-1:0]         out_TDATA,
    output logic                         out_TVALID,
    input  logic                         out_TREADY,
    output logic                         out_TLAST,
    output logic [ID_W-1:0]              out_TID,
    output logic                         busy
);

    localparam int DW = PE * ELEM_W;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   gnt_q, gnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [DW-1:0]     out_data_q, out_data_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;
    logic              busy_q, busy_d;

    logic [NREQ-1:0]   elig;
    logic              found;
    logic [ID_W-1:0]   pick;
    logic [ID_W-1:0]   cand;
    int unsigned       idx;
    logic [LEN_W-1:0]  pick_len;
    logic              gnt_valid;
    logic              slot_free;
    logic              accept;
    logic              last_beat;
    logic [NREQ-1:0]   tready;
    logic [DW-1:0]     a_sel, b_sel, sum;

    assign elig = req_in0_TVALID & req_in1_TVALID;

    // Scan rr_ptr, rr_ptr+1, ... modulo NREQ; first eligible wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = ID_W'(idx);
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign pick_len  = req_len[int'(pick)*LEN_W +: LEN_W];
    assign gnt_valid = req_in0_TVALID[gnt_q] & req_in1_TVALID[gnt_q];
    assign slot_free = !out_valid_q || out_TREADY;
    assign accept    = (state_q == RUN) && slot_free && gnt_valid;
    assign last_beat = (beat_cnt_q == len_q - LEN_W'(1));

    // Join: both operand streams of the granted requester move together or not at all.
    always_comb begin
        tready = '0;
        if (accept) tready[gnt_q] = 1'b1;
    end

    assign req_in0_TREADY = tready;
    assign req_in1_TREADY = tready;

    assign a_sel = req_in0_TDATA[int'(gnt_q)*DW +: DW];
    assign b_sel = req_in1_TDATA[int'(gnt_q)*DW +: DW];

    // Per-lane modular add; no carry crosses a lane boundary.
    for (genvar i = 0; i < PE; i++) begin : g_lane
        assign sum[i*ELEM_W +: ELEM_W] = a_sel[i*ELEM_W +: ELEM_W] + b_sel[i*ELEM_W +: ELEM_W];
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        len_d       = len_q;
        beat_cnt_d  = beat_cnt_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d      = pick;
                    len_d      = (pick_len == '0) ? LEN_W'(1) : pick_len;
                    rr_ptr_d   = (pick == ID_W'(NREQ - 1)) ? '0 : pick + ID_W'(1);
                    beat_cnt_d = '0;
                    state_d    = RUN;
                    busy_d     = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        state_d    = IDLE;
                        busy_d     = 1'b0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sum;
            out_last_d  = last_beat;
            out_id_d    = gnt_q;
        end else if (out_TREADY) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    assign out_TVALID = out_valid_q;
    assign out_TDATA  = out_data_q;
    assign out_TLAST  = out_last_q;
    assign out_TID    = out_id_q;
    assign busy       = busy_q;

endmodule
